// File: rtl/tdc_pkg.sv
// Shared types and helpers for the multi-channel pulse TDC.
// State encoding, interval limit and coincidence detection used by tdc_multi.
package tdc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } tdc_state_e;

    function automatic int unsigned max_interval(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_ge2(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/tdc_edge_sync.sv
// Per-channel synchroniser and registered rising-edge hit detector.
// Optional afterpulse dead time is compiled in with TDC_DEADTIME_EN.
module tdc_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DEAD_CYC    = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pulse,
    output logic o_hit
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;
    logic                   w_hit;

    // Chain and history start high so a level held across reset is not a hit.
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

`ifdef TDC_DEADTIME_EN
    localparam int DW = $clog2(DEAD_CYC + 1);

    logic [DW-1:0] r_dead;

    assign w_hit = w_edge & (r_dead == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dead <= '0;
        end else if (w_hit) begin
            r_dead <= DW'(DEAD_CYC);
        end else if (r_dead != '0) begin
            r_dead <= r_dead - DW'(1);
        end
    end
`else
    assign w_hit = w_edge;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit <= 1'b0;
        end else begin
            o_hit <= w_hit;
        end
    end

endmodule

// File: rtl/tdc_multi.sv
// N-channel time-to-digital converter: interval between consecutive hits in clk cycles.
// Build option TDC_DEADTIME_EN enables per-channel afterpulse masking in tdc_edge_sync.
//
// state | meaning
// IDLE  | no open interval, waiting for a start hit
// ARMED | interval open, counting cycles since last hit
module tdc_multi
    import tdc_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int DEAD_CYC    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_pulse_in,
    output logic             o_event_valid,
    output logic [N_CH-1:0]  o_start_ch,
    output logic [N_CH-1:0]  o_end_ch,
    output logic [CNT_W-1:0] o_interval,
    output logic             o_timeout,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] MAX_INT = CNT_W'(max_interval(CNT_W));

    tdc_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic [N_CH-1:0]  r_last_hit;
    logic [N_CH-1:0]  w_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_any_hit;
    logic             w_coinc;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tdc_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEAD_CYC    (DEAD_CYC)
        ) u_edge_sync (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_pulse (i_pulse_in[g]),
            .o_hit   (w_hit[g])
        );
    end

    assign w_cnt_inc = r_count + CNT_W'(1);
    assign w_any_hit = |w_hit;
    assign w_coinc   = popcount_ge2(8'(w_hit));
    assign o_busy    = (r_state == ARMED);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_last_hit    <= '0;
            o_event_valid <= 1'b0;
            o_start_ch    <= '0;
            o_end_ch      <= '0;
            o_interval    <= '0;
            o_timeout     <= 1'b0;
        end else begin
            o_event_valid <= 1'b0;
            o_timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_hit) begin
                        if (w_coinc) begin
                            o_event_valid <= 1'b1;
                            o_start_ch    <= '0;
                            o_end_ch      <= w_hit;
                            o_interval    <= '0;
                        end
                        r_last_hit <= w_hit;
                        r_count    <= '0;
                        r_state    <= ARMED;
                    end
                end
                ARMED: begin
                    // A hit in the expiry cycle takes priority over the timeout.
                    if (w_any_hit) begin
                        o_event_valid <= 1'b1;
                        o_start_ch    <= r_last_hit;
                        o_end_ch      <= w_hit;
                        o_interval    <= w_cnt_inc;
                        r_last_hit    <= w_hit;
                        r_count       <= '0;
                    end else if (w_cnt_inc == MAX_INT) begin
                        o_timeout  <= 1'b1;
                        r_last_hit <= '0;
                        r_count    <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_count <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_multi.sv
// Directed self-checking bench for tdc_multi (N_CH=2, CNT_W=7, SYNC_STAGES=2).
// Pulses are launched at negedges; an event from a rise at cycle C is observed at cycle C+4.
module tb_tdc_multi;

    localparam int N_CH  = 2;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_CH-1:0]  pulse_in = '0;
    logic             event_valid;
    logic [N_CH-1:0]  start_ch;
    logic [N_CH-1:0]  end_ch;
    logic [CNT_W-1:0] interval;
    logic             timeout;
    logic             busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int to_cnt = 0;
    int to_cyc = 0;
    int ev_s[$];
    int ev_e[$];
    int ev_i[$];
    int ev_c[$];
    int c0;

    tdc_multi #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .DEAD_CYC    (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pulse_in    (pulse_in),
        .o_event_valid (event_valid),
        .o_start_ch    (start_ch),
        .o_end_ch      (end_ch),
        .o_interval    (interval),
        .o_timeout     (timeout),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (event_valid) begin
            ev_s.push_back(int'(start_ch));
            ev_e.push_back(int'(end_ch));
            ev_i.push_back(int'(interval));
            ev_c.push_back(cyc);
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; pulse is high for one cycle, returns one negedge later.
    task automatic fire(input logic [N_CH-1:0] m, output int c);
        pulse_in = m;
        c = cyc;
        tick(1);
        pulse_in = '0;
    endtask

    task automatic do_reset();
        pulse_in = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        ev_s.delete();
        ev_e.delete();
        ev_i.delete();
        ev_c.delete();
        to_cnt = 0;
    endtask

    int cdum;

    initial begin
        tick(3);
        chk("rst_event_valid", int'(event_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_interval", int'(interval), 0);
        chk("rst_start", int'(start_ch), 0);
        chk("rst_end", int'(end_ch), 0);
        do_reset();

        // ch0 then ch0 ten cycles later
        fire(2'b01, c0);
        tick(9);
        fire(2'b01, cdum);
        tick(8);
        chk("t1_ev_count", ev_i.size(), 1);
        if (ev_i.size() >= 1) begin
            chk("t1_interval", ev_i[0], 10);
            chk("t1_start", ev_s[0], 1);
            chk("t1_end", ev_e[0], 1);
            chk("t1_latency", ev_c[0] - c0, 14);
        end
        chk("t1_hold_interval", int'(interval), 10);
        chk("t1_busy", int'(busy), 1);
        chk("t1_timeouts", to_cnt, 0);

        // coincidence from IDLE, then ch0 five cycles later
        do_reset();
        fire(2'b11, c0);
        tick(4);
        fire(2'b01, cdum);
        tick(8);
        chk("t2_ev_count", ev_i.size(), 2);
        if (ev_i.size() >= 2) begin
            chk("t2_coinc_interval", ev_i[0], 0);
            chk("t2_coinc_start", ev_s[0], 0);
            chk("t2_coinc_end", ev_e[0], 3);
            chk("t2_interval", ev_i[1], 5);
            chk("t2_start", ev_s[1], 3);
            chk("t2_end", ev_e[1], 1);
        end

        // ch1 alone: timeout 127 cycles later, late ch0 re-arms without event
        do_reset();
        fire(2'b10, c0);
        tick(129);
        fire(2'b01, cdum);
        tick(1);
        chk("t3_busy_after_to", int'(busy), 0);
        tick(7);
        chk("t3_to_count", to_cnt, 1);
        chk("t3_to_cycle", to_cyc - c0, 131);
        chk("t3_ev_count", ev_i.size(), 0);
        chk("t3_rearmed", int'(busy), 1);

        // second hit exactly at the expiry cycle wins
        do_reset();
        fire(2'b01, c0);
        tick(126);
        fire(2'b10, cdum);
        tick(8);
        chk("t4_ev_count", ev_i.size(), 1);
        if (ev_i.size() >= 1) begin
            chk("t4_interval", ev_i[0], 127);
            chk("t4_start", ev_s[0], 1);
            chk("t4_end", ev_e[0], 2);
        end
        chk("t4_to_count", to_cnt, 0);
        chk("t4_busy", int'(busy), 1);

        // reset mid-interval, then level held across reset release
        do_reset();
        fire(2'b01, c0);
        tick(9);
        fire(2'b01, cdum);
        tick(6);
        chk("t5_pre_interval", int'(interval), 10);
        chk("t5_pre_busy", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_interval", int'(interval), 0);
        chk("t5_rst_start", int'(start_ch), 0);
        chk("t5_rst_end", int'(end_ch), 0);
        ev_i.delete();
        to_cnt = 0;
        pulse_in = 2'b11;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("t5_held_ev_count", ev_i.size(), 0);
        chk("t5_held_busy", int'(busy), 0);
        chk("t5_held_to", to_cnt, 0);
        pulse_in = '0;
        tick(2);

`ifdef TDC_DEADTIME_EN
        // afterpulse 2 cycles later is masked; hit 6 cycles after the first is accepted
        do_reset();
        fire(2'b01, c0);
        tick(1);
        fire(2'b01, cdum);
        tick(3);
        fire(2'b01, cdum);
        tick(8);
        chk("t6_ev_count", ev_i.size(), 1);
        if (ev_i.size() >= 1) begin
            chk("t6_interval", ev_i[0], 6);
            chk("t6_start", ev_s[0], 1);
            chk("t6_end", ev_e[0], 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
